// File: rtl/keypad_scanner_if.sv
// Keypad-facing and converter-facing signals of the 4x4 keypad scanner.
// master = scanner side, slave = keypad/converter side.
interface keypad_scanner_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [7:0] eightBitButton;
  logic       validPress;
  logic       keyStrobe;

  modport master (input rows, output cols, eightBitButton, validPress, keyStrobe);
  modport slave  (output rows, input cols, eightBitButton, validPress, keyStrobe);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, 2-flop row sync, press/release debounce, multi-key reject; KEYPAD_AUTOREPEAT_EN adds repeat strobes.
// Press latency SCAN_DIV+DEBOUNCE_CNT from column activation; no backpressure, outputs are registered levels plus a 1-cycle strobe.
module keypad_scanner #(
  parameter logic [15:0] SCAN_DIV     = 16'd5000,
  parameter logic [19:0] DEBOUNCE_CNT = 20'd250000,
  parameter logic [23:0] REPEAT_CNT   = 24'd5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  keypad_scanner_if.master kp
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;
  typedef struct packed {
    logic [3:0] col;
    logic [3:0] row;
  } key_t;

  localparam key_t KEY_NONE = 8'hFF;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_sync1, r_sync2;
  logic [3:0]  r_cols, w_cols_nxt;
  logic [15:0] r_dwell, w_dwell_nxt;
  logic [19:0] r_dbc, w_dbc_nxt;
  key_t        r_cand, w_cand_nxt;
  key_t        r_code, w_code_nxt;
  logic        r_vld, w_vld_nxt;
  logic        r_stb, w_stb_nxt;

  logic        w_one, w_idle, w_match, w_dwell_end, w_dbc_end;

  assign w_one       = $onehot(~r_sync2);
  assign w_idle      = &r_sync2;
  assign w_match     = (r_sync2 == r_cand.row);
  assign w_dwell_end = (r_dwell == SCAN_DIV - 16'd1);
  assign w_dbc_end   = (r_dbc == DEBOUNCE_CNT - 20'd1);

`ifdef KEYPAD_AUTOREPEAT_EN
  logic [23:0] r_rep, w_rep_nxt;
  logic        w_rep_end;
  assign w_rep_end = (r_rep == REPEAT_CNT - 24'd1);
`else
  // The repeat interval has no effect without auto-repeat.
  if (REPEAT_CNT == 24'd0) begin : g_no_repeat_interval
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= kp.rows;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SCAN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SCAN:     if (w_dwell_end && w_one) w_state_nxt = DEBOUNCE;
      DEBOUNCE: if (!w_match)             w_state_nxt = SCAN;
                else if (w_dbc_end)       w_state_nxt = PRESSED;
      PRESSED:  if (!w_match)             w_state_nxt = RELEASE;
      RELEASE:  if (w_match)              w_state_nxt = PRESSED;
                else if (w_idle && w_dbc_end) w_state_nxt = SCAN;
      default:  w_state_nxt = SCAN;
    endcase
  end

  always_comb begin
    w_cols_nxt  = r_cols;
    w_dwell_nxt = r_dwell;
    w_dbc_nxt   = r_dbc;
    w_cand_nxt  = r_cand;
    w_code_nxt  = r_code;
    w_vld_nxt   = r_vld;
    w_stb_nxt   = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    w_rep_nxt   = 24'd0;
`endif
    case (r_state)
      SCAN: begin
        if (w_dwell_end) begin
          w_dwell_nxt = 16'd0;
          if (w_one) begin
            w_cand_nxt = {r_cols, r_sync2};
            w_dbc_nxt  = 20'd0;
          end else begin
            w_cols_nxt = {r_cols[0], r_cols[3:1]};
          end
        end else begin
          w_dwell_nxt = r_dwell + 16'd1;
        end
      end
      DEBOUNCE: begin
        if (!w_match) begin
          w_dwell_nxt = 16'd0;
        end else if (w_dbc_end) begin
          w_code_nxt = r_cand;
          w_vld_nxt  = 1'b1;
          w_stb_nxt  = 1'b1;
        end else begin
          w_dbc_nxt = r_dbc + 20'd1;
        end
      end
      PRESSED: begin
        if (!w_match) begin
          w_dbc_nxt = 20'd0;
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
          if (w_rep_end) w_stb_nxt = 1'b1;
          else           w_rep_nxt = r_rep + 24'd1;
`endif
        end
      end
      RELEASE: begin
        // Any non-idle pattern other than the held key breaks the idle run.
        if (!w_match) begin
          if (!w_idle) begin
            w_dbc_nxt = 20'd0;
          end else if (w_dbc_end) begin
            w_vld_nxt   = 1'b0;
            w_code_nxt  = KEY_NONE;
            w_cols_nxt  = {r_cols[0], r_cols[3:1]};
            w_dwell_nxt = 16'd0;
          end else begin
            w_dbc_nxt = r_dbc + 20'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cols  <= 4'b0111;
      r_dwell <= 16'd0;
      r_dbc   <= 20'd0;
      r_cand  <= KEY_NONE;
      r_code  <= KEY_NONE;
      r_vld   <= 1'b0;
      r_stb   <= 1'b0;
    end else begin
      r_cols  <= w_cols_nxt;
      r_dwell <= w_dwell_nxt;
      r_dbc   <= w_dbc_nxt;
      r_cand  <= w_cand_nxt;
      r_code  <= w_code_nxt;
      r_vld   <= w_vld_nxt;
      r_stb   <= w_stb_nxt;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rep <= 24'd0;
    else        r_rep <= w_rep_nxt;
  end
`endif

  assign kp.cols           = r_cols;
  assign kp.eightBitButton = r_code;
  assign kp.validPress     = r_vld;
  assign kp.keyStrobe      = r_stb;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

- Scans the 4x4 keypad and produces a debounced 8-bit key code, `eightBitButton`, with a qualifying `validPress` level.
- Sits directly upstream of the 8-bit-to-5-bit button converter and drives that stage's `eightBitButton` and `validPress` inputs.
- Handles column drive, row synchronisation, press/release debounce and multi-key rejection.

## Interface
Parameters:
- `SCAN_DIV`, 16'd5000: clock cycles each column is driven; minimum 3.
- `DEBOUNCE_CNT`, 20'd250000: consecutive stable cycles required to accept a press or a release; minimum 1.
- `REPEAT_CNT`, 24'd5000000: auto-repeat interval in cycles; only used with `KEYPAD_AUTOREPEAT_EN`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rows`  in  4  keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `cols`  out  4  column drive, active-low one-cold; bit 3 = column 0.
- `eightBitButton`  out  8  {active column, row pattern}, both active-low; 8'hFF when no key.
- `validPress`  out  1  high while a debounced key is held.
- `keyStrobe`  out  1  one-cycle pulse per accepted press.

## Operation
- `rows` passes through a 2-flop synchroniser (`rowsSync`) before any use.
- A row pattern is valid only if exactly one bit is 0. 4'b1111 means idle. Two or more zero bits count as a multi-key pattern and are never accepted.

States:
- SCAN
  - The dwell counter counts 0..SCAN_DIV-1 on the current column.
  - At count SCAN_DIV-1, sample `rowsSync`.
  - If the sample is valid: capture {`cols`, `rowsSync`} into `candidate`, clear the debounce counter, go to DEBOUNCE. The column is held.
  - Otherwise: advance to the next column (0->1->2->3->0) and restart the dwell counter.
- DEBOUNCE
  - While `rowsSync` equals the candidate rows, count up.
  - On reaching DEBOUNCE_CNT: load `eightBitButton` with `candidate`, set `validPress`, pulse `keyStrobe`, go to PRESSED.
  - On any mismatch: go to SCAN on the same column with dwell reset. No output change.
- PRESSED
  - Stay while `rowsSync` equals the candidate rows.
  - Otherwise go to RELEASE with the counter cleared.
- RELEASE
  - Count consecutive cycles of `rowsSync` == 4'b1111.
  - On reaching DEBOUNCE_CNT: `validPress` goes to 0, `eightBitButton` goes to 8'hFF, go to SCAN on the next column.
  - If `rowsSync` returns to the candidate rows: go back to PRESSED with no new `keyStrobe`.
  - Any other non-idle pattern: the counter restarts from 0.
- `eightBitButton` is constant for the whole time `validPress` is high. It is 8'hFF whenever `validPress` is low.
- A second key pressed while one is held is ignored until a full release completes. No rollover.

## Timing
Reset values (asserted asynchronously on `rst_n` low):
- `cols` = 4'b0111.
- `eightBitButton` = 8'hFF.
- `validPress` = 0, `keyStrobe` = 0.
- State SCAN; all counters 0.
- Reset mid-press drops `validPress` immediately, with no strobe.

Latency:
- Column k becomes active at edge t with the key already stable for at least 2 cycles.
- The sample is taken at t+SCAN_DIV-1.
- `validPress` and `keyStrobe` are registered high at t+SCAN_DIV+DEBOUNCE_CNT.
- Release: `validPress` falls DEBOUNCE_CNT+1 cycles after `rowsSync` first reads 4'b1111. A 2-cycle synchroniser delay precedes this.

Outputs and handshake:
- All outputs are registered; there are no combinational paths from `rows`.
- `eightBitButton` changes only on the same edge that `validPress` changes, so the converter samples a stable code.
- Worst-case scan period with no key pressed: 4*SCAN_DIV cycles.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined:
  - In PRESSED, a repeat counter pulses `keyStrobe` every REPEAT_CNT cycles after the initial strobe.
  - The counter is cleared when leaving PRESSED.
  - `validPress` stays high throughout.
- `KEYPAD_AUTOREPEAT_EN` undefined:
  - Exactly one `keyStrobe` per press.
  - The repeat counter is not synthesised.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_CNT=20.
- Reset -> `cols`=4'b0111, `eightBitButton`=8'hFF, `validPress`=0; `cols` rotates 0111,1011,1101,1110 every 4 cycles.
- Hold the "5" key (row 1 low while `cols`=1011) -> `eightBitButton`=8'hBB, `validPress`=1, exactly one `keyStrobe`; after release plus 8 idle cycles -> 8'hFF, `validPress`=0.
- Bounce during DEBOUNCE: toggle the row 3 times within 8 cycles, then release -> no `validPress`, no strobe, scanning resumes.
- Rows 0 and 2 low together on column 3 -> never accepted; `cols` keeps rotating.
- Bounce on release (rows go idle 4 cycles, then back to the candidate) -> `validPress` stays 1, no second strobe; "A" key code 8'h7E held.
- `rst_n` low mid-press -> outputs at reset values within the same cycle. With `KEYPAD_AUTOREPEAT_EN`, holding "=" (8'hDE) gives strobes 20 cycles apart.
